// File: rtl/ram_seq_pkg.sv
// Shared types and constants for the RAM sequencer and its dwell counter.
package ram_seq_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 3;
    localparam int unsigned RAM_RD_LAT = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WRITE,
        S_ISSUE,
        S_CAPTURE,
        S_DWELL
    } seq_state_t;

endpackage

// File: rtl/ram_sequencer_dwell.sv
// Counts the cycles an address is held during scan; tc marks the last one.
module dwell_counter #(
    parameter int unsigned DWELL = 50_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/ram_sequencer.sv
// Initiator for the 32x3 synchronous RAM: fill, continuous display scan and
// single writes, including writes slipped into the dwell period of a scan.
module ram_sequencer
    import ram_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DWELL  = 50_000_000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start_fill,
    input  logic [DATA_W-1:0] fill_value,
    input  logic              start_scan,
    input  logic              stop,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_enable,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_datain,
    input  logic [DATA_W-1:0] ram_dataout,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              busy,
    output logic              done
);

    seq_state_t        state, nstate;
    logic [ADDR_W-1:0] fill_addr;
    logic [ADDR_W-1:0] scan_addr;
    logic [DATA_W-1:0] fill_val;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              resume_scan;
    logic              dw_clear;
    logic              dw_en;
    logic              dw_tc;

    dwell_counter #(.DWELL(DWELL)) u_dwell (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (dw_clear),
        .enable  (dw_en),
        .tc      (dw_tc)
    );

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE: begin
                if (start_fill)      nstate = S_FILL;
                else if (wr_req)     nstate = S_WRITE;
                else if (start_scan) nstate = S_ISSUE;
            end
            S_FILL:    if (fill_addr == '1) nstate = S_IDLE;
            S_WRITE:   nstate = resume_scan ? S_ISSUE : S_IDLE;
            S_ISSUE:   nstate = stop ? S_IDLE : S_CAPTURE;
            S_CAPTURE: nstate = stop ? S_IDLE : S_DWELL;
            S_DWELL: begin
                if (stop)        nstate = S_IDLE;
                else if (wr_req) nstate = S_WRITE;
                else if (dw_tc)  nstate = S_ISSUE;
            end
            default:   nstate = S_IDLE;
        endcase
    end

    // Counter runs from ISSUE and restarts on every (re-)entry to ISSUE.
    always_comb begin
        dw_en    = (state inside {S_ISSUE, S_CAPTURE, S_DWELL});
        dw_clear = !(nstate inside {S_CAPTURE, S_DWELL});
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            fill_addr   <= '0;
            scan_addr   <= '0;
            fill_val    <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            resume_scan <= 1'b0;
            disp_addr   <= '0;
            disp_data   <= '0;
            disp_valid  <= 1'b0;
            done        <= 1'b0;
        end else begin
            state      <= nstate;
            disp_valid <= 1'b0;
            done       <= (state == S_FILL) && (nstate == S_IDLE);
            case (state)
                S_IDLE: begin
                    if (start_fill) begin
                        fill_val  <= fill_value;
                        fill_addr <= '0;
                    end else if (wr_req) begin
                        wr_addr_q   <= wr_addr;
                        wr_data_q   <= wr_data;
                        resume_scan <= 1'b0;
                    end else if (start_scan) begin
                        scan_addr <= '0;
                    end
                end
                S_FILL: fill_addr <= fill_addr + ADDR_W'(1);
                S_CAPTURE: begin
                    disp_data  <= ram_dataout;
                    disp_addr  <= scan_addr;
                    disp_valid <= 1'b1;
                end
                S_DWELL: begin
                    if (!stop) begin
                        if (wr_req) begin
                            wr_addr_q   <= wr_addr;
                            wr_data_q   <= wr_data;
                            resume_scan <= 1'b1;
                        end else if (dw_tc) begin
                            scan_addr <= scan_addr + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM port is decoded purely from registered state, so reset clears it at once.
    always_comb begin
        ram_enable  = 1'b0;
        ram_wren    = 1'b0;
        ram_address = '0;
        ram_datain  = '0;
        case (state)
            S_FILL: begin
                ram_enable  = 1'b1;
                ram_wren    = 1'b1;
                ram_address = fill_addr;
                ram_datain  = fill_val;
            end
            S_WRITE: begin
                ram_enable  = 1'b1;
                ram_wren    = 1'b1;
                ram_address = wr_addr_q;
                ram_datain  = wr_data_q;
            end
            S_ISSUE: begin
                ram_enable  = 1'b1;
                ram_address = scan_addr;
            end
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ram_sequencer.sv
// Bench for ram_sequencer with a behavioural 32x3 RAM responder and a
// reference image of memory contents plus scan-timing arithmetic.
module tb_ram_sequencer;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 3;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned DWL = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start_fill = 1'b0;
    logic [DW-1:0] fill_value = '0;
    logic          start_scan = 1'b0;
    logic          stop = 1'b0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [AW-1:0] ram_address;
    logic          ram_enable;
    logic          ram_wren;
    logic [DW-1:0] ram_datain;
    logic [DW-1:0] ram_dataout = '0;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          disp_valid;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    int            n_cmp = 0;
    int            n_err = 0;

    ram_sequencer #(.ADDR_W(AW), .DATA_W(DW), .DWELL(DWL)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start_fill  (start_fill),
        .fill_value  (fill_value),
        .start_scan  (start_scan),
        .stop        (stop),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .ram_address (ram_address),
        .ram_enable  (ram_enable),
        .ram_wren    (ram_wren),
        .ram_datain  (ram_datain),
        .ram_dataout (ram_dataout),
        .disp_addr   (disp_addr),
        .disp_data   (disp_data),
        .disp_valid  (disp_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_enable) begin
            if (ram_wren) mem[ram_address] <= ram_datain;
            else          ram_dataout <= mem[ram_address];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({ram_enable, ram_wren, ram_address, ram_datain, disp_valid, disp_addr, disp_data, busy, done} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got en=%b wr=%b a=%0d d=%0d busy=%b done=%b, want all 0",
                     ram_enable, ram_wren, ram_address, ram_datain, busy, done);
        end
        reset_n = 1'b1;
        tick();
        n_cmp++;
        if ({ram_enable, busy, done, disp_valid} !== 4'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: got en=%b busy=%b done=%b dv=%b, want 0", ram_enable, busy, done, disp_valid);
        end
    endtask

    task automatic test_fill(input logic [DW-1:0] v);
        int done_seen;
        done_seen = 0;
        start_fill = 1'b1;
        fill_value = v;
        tick();
        start_fill = 1'b0;
        fill_value = DW'($urandom);
        for (int i = 0; i < int'(DEPTH); i++) begin
            n_cmp++;
            if ({ram_enable, ram_wren, ram_address, ram_datain, busy, done} !== {2'b11, AW'(i), v, 2'b10}) begin
                n_err++;
                $display("FAIL fill_cycle%0d: got en=%b wr=%b a=%0d d=%0d busy=%b done=%b, want 1 1 %0d %0d 1 0",
                         i, ram_enable, ram_wren, ram_address, ram_datain, busy, done, i, v);
            end
            tick();
        end
        n_cmp++;
        if ({busy, done, ram_enable, ram_wren} !== 4'b0100) begin
            n_err++;
            $display("FAIL fill_done: got busy=%b done=%b en=%b wr=%b, want 0 1 0 0", busy, done, ram_enable, ram_wren);
        end
        if (done) done_seen++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) done_seen++;
        end
        n_cmp++;
        if (done_seen != 1) begin
            n_err++;
            $display("FAIL fill_done_count: got %0d pulses, want 1", done_seen);
        end
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = v;
    endtask

    task automatic test_scan_wrap;
        int k;
        logic exp_valid, exp_en;
        start_scan = 1'b1;
        tick();
        start_scan = 1'b0;
        // t counts negedges after acceptance; ISSUE at t=4k+1, valid at t=4k+3
        for (int t = 1; t <= 3 + 4 * int'(DEPTH); t++) begin
            exp_en    = (t % 4 == 1);
            exp_valid = (t >= 3) && ((t - 3) % 4 == 0);
            n_cmp++;
            if ({ram_enable, disp_valid, busy} !== {exp_en, exp_valid, 1'b1}) begin
                n_err++;
                $display("FAIL scan_timing t=%0d: got en=%b dv=%b busy=%b, want %b %b 1",
                         t, ram_enable, disp_valid, busy, exp_en, exp_valid);
            end
            if (exp_en) begin
                k = (t / 4) % int'(DEPTH);
                n_cmp++;
                if ({ram_wren, ram_address} !== {1'b0, AW'(k)}) begin
                    n_err++;
                    $display("FAIL scan_read t=%0d: got wr=%b a=%0d, want 0 %0d", t, ram_wren, ram_address, k);
                end
            end
            if (exp_valid) begin
                k = ((t - 3) / 4) % int'(DEPTH);
                n_cmp++;
                if ({disp_addr, disp_data} !== {AW'(k), ref_mem[k]}) begin
                    n_err++;
                    $display("FAIL scan_disp t=%0d: got a=%0d d=%0d, want %0d %0d", t, disp_addr, disp_data, k, ref_mem[k]);
                end
            end
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_cmp++;
        if ({busy, ram_enable} !== 2'b00) begin
            n_err++;
            $display("FAIL scan_stop: got busy=%b en=%b, want 0 0", busy, ram_enable);
        end
    endtask

    task automatic test_write_during_scan(input logic [AW-1:0] s, input logic [AW-1:0] w, input logic [DW-1:0] d);
        int budget;
        int k;
        start_scan = 1'b1;
        tick();
        start_scan = 1'b0;
        budget = 4 * int'(DEPTH) + 8;
        while (!(disp_valid && disp_addr == s) && budget > 0) begin
            tick();
            budget--;
        end
        n_cmp++;
        if (budget == 0) begin
            n_err++;
            $display("FAIL wscan_wait: got no capture of addr %0d, want one within budget", s);
        end
        wr_req  = 1'b1;
        wr_addr = w;
        wr_data = d;
        tick();
        wr_req  = 1'b0;
        wr_addr = AW'($urandom);
        wr_data = DW'($urandom);
        n_cmp++;
        if ({ram_enable, ram_wren, ram_address, ram_datain} !== {2'b11, w, d}) begin
            n_err++;
            $display("FAIL wscan_write: got en=%b wr=%b a=%0d d=%0d, want 1 1 %0d %0d",
                     ram_enable, ram_wren, ram_address, ram_datain, w, d);
        end
        ref_mem[w] = d;
        tick();
        n_cmp++;
        if ({ram_enable, ram_wren, ram_address} !== {2'b10, s}) begin
            n_err++;
            $display("FAIL wscan_reread: got en=%b wr=%b a=%0d, want 1 0 %0d", ram_enable, ram_wren, ram_address, s);
        end
        tick();
        tick();
        // valid now at t=0; subsequent captures every DWELL cycles walk forward from s
        for (int t = 0; t <= 4 * int'(DEPTH); t++) begin
            n_cmp++;
            if (disp_valid !== (t % 4 == 0)) begin
                n_err++;
                $display("FAIL wscan_timing t=%0d: got dv=%b, want %b", t, disp_valid, (t % 4 == 0));
            end
            if (t % 4 == 0) begin
                k = (int'(s) + t / 4) % int'(DEPTH);
                n_cmp++;
                if ({disp_addr, disp_data} !== {AW'(k), ref_mem[k]}) begin
                    n_err++;
                    $display("FAIL wscan_disp t=%0d: got a=%0d d=%0d, want %0d %0d", t, disp_addr, disp_data, k, ref_mem[k]);
                end
            end
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_priority;
        logic [DW-1:0] v;
        logic [AW-1:0] a;
        v = DW'($urandom);
        a = AW'($urandom);
        start_fill = 1'b1;
        fill_value = v;
        wr_req     = 1'b1;
        wr_addr    = a;
        wr_data    = ~v;
        start_scan = 1'b1;
        tick();
        start_fill = 1'b0;
        wr_req     = 1'b0;
        start_scan = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            n_cmp++;
            if ({ram_enable, ram_wren, ram_address, ram_datain} !== {2'b11, AW'(i), v}) begin
                n_err++;
                $display("FAIL prio_fill%0d: got en=%b wr=%b a=%0d d=%0d, want 1 1 %0d %0d",
                         i, ram_enable, ram_wren, ram_address, ram_datain, i, v);
            end
            stop       = (i >= 3 && i < 8);
            wr_req     = (i == 10);
            start_scan = (i == 20);
            tick();
        end
        stop       = 1'b0;
        wr_req     = 1'b0;
        start_scan = 1'b0;
        n_cmp++;
        if ({busy, done} !== 2'b01) begin
            n_err++;
            $display("FAIL prio_done: got busy=%b done=%b, want 0 1", busy, done);
        end
        tick();
        n_cmp++;
        if (mem[a] !== v) begin
            n_err++;
            $display("FAIL prio_dropped_write: got mem[%0d]=%0d, want %0d", a, mem[a], v);
        end
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = v;
    endtask

    task automatic test_reset_mid_fill;
        logic [DW-1:0] b;
        b = ref_mem[0] ^ DW'($urandom_range(1, 7));
        start_fill = 1'b1;
        fill_value = b;
        tick();
        start_fill = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        n_cmp++;
        if ({ram_wren, ram_address} !== {1'b1, AW'(10)}) begin
            n_err++;
            $display("FAIL rst_fill_pos: got wr=%b a=%0d, want 1 10", ram_wren, ram_address);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({ram_enable, ram_wren, ram_address, ram_datain, disp_valid, disp_addr, disp_data, busy, done} !== '0) begin
            n_err++;
            $display("FAIL rst_fill_outputs: got en=%b wr=%b a=%0d d=%0d busy=%b, want all 0",
                     ram_enable, ram_wren, ram_address, ram_datain, busy);
        end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) ref_mem[i] = b;
        start_scan = 1'b1;
        tick();
        start_scan = 1'b0;
        tick();
        for (int k = 0; k < int'(DEPTH); k++) begin
            tick();
            n_cmp++;
            if ({disp_valid, disp_addr, disp_data} !== {1'b1, AW'(k), ref_mem[k]}) begin
                n_err++;
                $display("FAIL rst_fill_scan%0d: got dv=%b a=%0d d=%0d, want 1 %0d %0d",
                         k, disp_valid, disp_addr, disp_data, k, ref_mem[k]);
            end
            tick();
            tick();
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_stop;
        int budget;
        start_scan = 1'b1;
        tick();
        start_scan = 1'b0;
        budget = 4 * int'(DEPTH) + 8;
        while (!(disp_valid && disp_addr == AW'(4)) && budget > 0) begin
            tick();
            budget--;
        end
        n_cmp++;
        if (budget == 0) begin
            n_err++;
            $display("FAIL stop_wait: got no capture of addr 4, want one within budget");
        end
        tick();
        tick();
        tick();
        n_cmp++;
        if ({busy, ram_enable} !== 2'b10) begin
            n_err++;
            $display("FAIL stop_in_capture: got busy=%b en=%b, want 1 0", busy, ram_enable);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_cmp++;
        if ({busy, ram_enable, disp_addr, disp_data} !== {2'b00, AW'(5), ref_mem[5]}) begin
            n_err++;
            $display("FAIL stop_idle: got busy=%b en=%b a=%0d d=%0d, want 0 0 5 %0d",
                     busy, ram_enable, disp_addr, disp_data, ref_mem[5]);
        end
        start_scan = 1'b1;
        tick();
        start_scan = 1'b0;
        n_cmp++;
        if ({ram_enable, ram_wren, ram_address} !== {2'b10, AW'(0)}) begin
            n_err++;
            $display("FAIL stop_issue_read: got en=%b wr=%b a=%0d, want 1 0 0", ram_enable, ram_wren, ram_address);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if ({busy, disp_valid, disp_addr} !== {2'b00, AW'(5)}) begin
                n_err++;
                $display("FAIL stop_in_issue%0d: got busy=%b dv=%b a=%0d, want 0 0 5", i, busy, disp_valid, disp_addr);
            end
            tick();
        end
    endtask

    initial begin
        logic [AW-1:0] rs, rw;
        logic [DW-1:0] rd;
        test_reset();
        test_fill(3'b101);
        test_scan_wrap();
        test_write_during_scan(AW'(7), AW'(7), 3'b010);
        rs = AW'($urandom);
        rw = AW'($urandom);
        rd = DW'($urandom);
        test_write_during_scan(rs, rw, rd);
        test_priority();
        test_reset_mid_fill();
        test_stop();
        test_fill(DW'($urandom));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
